// File: rtl/panel_pkg.sv
// Shared definitions for the 5x7 column-multiplexed LED panel bus.
// Used by the receive-side frame capture block and by the driver-side bench.
//   PANEL_ROWS / PANEL_COLS : panel geometry
//   cap_state_e             : capture FSM states
//   col_class_e             : classification of a stable column strobe pattern
//   is_onehot / col_index   : strobe decoding helpers
package panel_pkg;

  localparam int PANEL_ROWS  = 5;
  localparam int PANEL_COLS  = 7;
  localparam int FRAME_BITS  = PANEL_ROWS * PANEL_COLS;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } cap_state_e;

  typedef enum logic [1:0] {
    COL_BLANK  = 2'd0,
    COL_ONEHOT = 2'd1,
    COL_MULTI  = 2'd2
  } col_class_e;

  // Exactly one strobe set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [PANEL_COLS-1:0] c);
    return (c != '0) && ((c & (c - PANEL_COLS'(1))) == '0);
  endfunction

  // Index of the highest set strobe; only meaningful for one-hot inputs.
  function automatic logic [2:0] col_index(input logic [PANEL_COLS-1:0] c);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < PANEL_COLS; i++) begin
      if (c[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic col_class_e col_classify(input logic [PANEL_COLS-1:0] c);
    col_class_e cls;
    if (c == '0)          cls = COL_BLANK;
    else if (is_onehot(c)) cls = COL_ONEHOT;
    else                  cls = COL_MULTI;
    return cls;
  endfunction

endpackage

// File: rtl/sample_filter.sv
// Input synchronizer and stability filter for an asynchronous parallel bus.
// A pattern must be seen unchanged for STABLE_CYCLES consecutive compares
// before it is accepted; accept_o pulses once per held pattern.
//   clk_i     : system clock
//   rst_n_i   : asynchronous active-low reset
//   din_i     : raw asynchronous bus
//   sample_o  : synchronized bus sample
//   accept_o  : one-cycle strobe, sample_o is the accepted pattern
module sample_filter #(
  parameter int WIDTH         = 12,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sample_o,
  output logic             accept_o
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [CW-1:0]    cnt_q;
  logic             same;

  assign same     = (sync2_q == prev_q);
  assign sample_o = sync2_q;
  // Fires only on the step into saturation, so a held pattern is accepted once.
  assign accept_o = same && (cnt_q == CNT_MAX - CW'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!same)                cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_frame_capture.sv
// Receive-side decoder for the column-multiplexed 5x7 LED panel bus.
// Filters the scanned strobes/rows and rebuilds the full 35-pixel frame.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   col         : column strobes C6..C0 (async, expected one-hot)
//   row         : row data L4..L0 for the strobed column (async)
//   frame       : last complete frame, bit c*5+r = row r of column c
//   frame_valid : one-cycle pulse when frame is updated
//   frame_error : one-cycle pulse on scan-order or one-hot violation
//   frame_count : completed frames, wraps at 256
//
// state   | meaning
// HUNT    | waiting for column 0 to start a frame
// COLLECT | columns 0..exp_col-1 stored in shadow, expecting exp_col next
module matrix_frame_capture
  import panel_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PANEL_COLS-1:0] col,
  input  logic [PANEL_ROWS-1:0] row,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [7:0]            frame_count
);

  localparam int         SW       = PANEL_COLS + PANEL_ROWS;
  localparam logic [2:0] LAST_COL = 3'(PANEL_COLS - 1);

  logic [SW-1:0]         sample;
  logic                  accept;
  logic [PANEL_COLS-1:0] s_col;
  logic [PANEL_ROWS-1:0] s_row;
  col_class_e            s_class;
  logic [2:0]            s_idx;

  cap_state_e            state_q;
  logic [2:0]            exp_col_q;
  logic [FRAME_BITS-1:0] shadow_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  frame_valid_q;
  logic                  frame_error_q;
  logic [7:0]            frame_count_q;

  sample_filter #(
    .WIDTH         (SW),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .din_i    ({col, row}),
    .sample_o (sample),
    .accept_o (accept)
  );

  assign s_col   = sample[SW-1:PANEL_ROWS];
  assign s_row   = sample[PANEL_ROWS-1:0];
  assign s_class = col_classify(s_col);
  assign s_idx   = col_index(s_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      exp_col_q     <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      if (accept) begin
        case (state_q)
          HUNT: begin
            if (s_class == COL_ONEHOT && s_idx == 3'd0) begin
              shadow_q  <= {{(FRAME_BITS-PANEL_ROWS){1'b0}}, s_row};
              exp_col_q <= 3'd1;
              state_q   <= COLLECT;
            end else if (s_class == COL_MULTI) begin
              frame_error_q <= 1'b1;
            end
          end
          COLLECT: begin
            case (s_class)
              COL_ONEHOT: begin
                if (s_idx == exp_col_q) begin
                  shadow_q[int'(s_idx)*PANEL_ROWS +: PANEL_ROWS] <= s_row;
                  exp_col_q <= exp_col_q + 3'd1;
                  if (s_idx == LAST_COL) begin
                    // Last column bypasses the shadow so the frame lands whole.
                    frame_q       <= {s_row, shadow_q[FRAME_BITS-PANEL_ROWS-1:0]};
                    frame_valid_q <= 1'b1;
                    frame_count_q <= frame_count_q + 8'd1;
                    exp_col_q     <= '0;
                    state_q       <= HUNT;
                  end
                end else if (s_idx == 3'd0) begin
                  // Early restart: treat as the start of a new frame.
                  frame_error_q <= 1'b1;
                  shadow_q      <= {{(FRAME_BITS-PANEL_ROWS){1'b0}}, s_row};
                  exp_col_q     <= 3'd1;
                end else begin
                  frame_error_q <= 1'b1;
                  exp_col_q     <= '0;
                  state_q       <= HUNT;
                end
              end
              COL_BLANK: begin
                exp_col_q <= '0;
                state_q   <= HUNT;
              end
              default: begin
                frame_error_q <= 1'b1;
                exp_col_q     <= '0;
                state_q       <= HUNT;
              end
            endcase
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_matrix_frame_capture.sv
module tb_matrix_frame_capture;
  import panel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  col = '0;
  logic [4:0]  row = '0;
  logic [34:0] frame;
  logic        frame_valid;
  logic        frame_error;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  matrix_frame_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col         (col),
    .row         (row),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [34:0] frame;
    logic [7:0]  count;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;
  int          n_error = 0;
  logic [7:0]  exp_count = '0;
  logic [34:0] last_frame = '0;
  logic [34:0] clean_pat;

  // Drives a bus pattern for d clock edges, returning 2 time units after an edge.
  task automatic hold(input logic [6:0] c, input logic [4:0] r, input int d);
    col = c;
    row = r;
    repeat (d) @(posedge clk);
    #2;
  endtask

  task automatic expect_frame(input logic [34:0] pat);
    exp_t e;
    exp_count  = exp_count + 8'd1;
    last_frame = pat;
    e.frame    = pat;
    e.count    = exp_count;
    sb_q.push_back(e);
  endtask

  task automatic scan_cols(input logic [34:0] pat, input int first, input int last,
                           input int dwell, input bit glitch);
    logic [6:0] oh;
    for (int c = first; c <= last; c++) begin
      if (glitch && c > first) hold(7'b0000011, pat[(c-1)*5 +: 5], 2);
      oh = 7'b1 << c;
      hold(oh, pat[c*5 +: 5], dwell);
    end
  endtask

  function automatic logic [34:0] rand_pat();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[34:0];
  endfunction

  task automatic mon_scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_valid || frame_error) begin
          checks++;
          if ((frame_valid && frame_error) !== 1'b0) begin
            errors++;
            $display("FAIL valid_error_overlap: both pulses high at %0t", $time);
          end
        end
        if (frame_error) n_error++;
        if (frame_valid) begin
          n_valid++;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: frame_valid with frame %h, none expected", frame);
          end else begin
            e = sb_q.pop_front();
            if (frame !== e.frame) begin
              errors++;
              $display("FAIL sb_frame: got %h expected %h", frame, e.frame);
            end
            checks++;
            if (frame_count !== e.count) begin
              errors++;
              $display("FAIL sb_count: got %0d expected %0d", frame_count, e.count);
            end
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected frames never produced", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (frame !== 35'd0)       begin errors++; $display("FAIL reset_frame: got %h expected 0", frame); end
    checks++; if (frame_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_error !== 1'b0)  begin errors++; $display("FAIL reset_error: got %b expected 0", frame_error); end
    checks++; if (frame_count !== 8'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    checks++; if (dut.state_q !== HUNT)  begin errors++; $display("FAIL reset_state: got %0d expected HUNT", dut.state_q); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    hold(7'd0, 5'd0, 10);
  endtask

  task automatic test_clean();
    int v0 = n_valid, e0 = n_error;
    clean_pat = {5'b00100, 5'b01010, 5'b10001, 5'b00000, 5'b11111, 5'b01110, 5'b10101};
    expect_frame(clean_pat);
    scan_cols(clean_pat, 0, 6, 10, 1'b0);
    hold(7'd0, 5'd0, 30);
    checks++; if (n_valid - v0 !== 1)     begin errors++; $display("FAIL clean_valid: got %0d pulses expected 1", n_valid - v0); end
    checks++; if (n_error - e0 !== 0)     begin errors++; $display("FAIL clean_error: got %0d pulses expected 0", n_error - e0); end
    checks++; if (frame !== clean_pat)    begin errors++; $display("FAIL clean_frame: got %h expected %h", frame, clean_pat); end
    checks++; if (frame_count !== 8'd1)   begin errors++; $display("FAIL clean_count: got %0d expected 1", frame_count); end
    check_drained("clean");
  endtask

  task automatic test_glitch();
    int v0 = n_valid, e0 = n_error;
    expect_frame(clean_pat);
    scan_cols(clean_pat, 0, 6, 10, 1'b1);
    hold(7'd0, 5'd0, 30);
    checks++; if (n_valid - v0 !== 1)     begin errors++; $display("FAIL glitch_valid: got %0d pulses expected 1", n_valid - v0); end
    checks++; if (n_error - e0 !== 0)     begin errors++; $display("FAIL glitch_error: got %0d pulses expected 0", n_error - e0); end
    checks++; if (frame !== clean_pat)    begin errors++; $display("FAIL glitch_frame: got %h expected %h", frame, clean_pat); end
    checks++; if (frame_count !== 8'd2)   begin errors++; $display("FAIL glitch_count: got %0d expected 2", frame_count); end
    check_drained("glitch");
  endtask

  task automatic test_skip();
    int v0 = n_valid, e0 = n_error;
    logic [34:0] p = rand_pat();
    scan_cols(p, 0, 2, 10, 1'b0);
    hold(7'b0010000, p[24:20], 10);
    hold(7'd0, 5'd0, 30);
    checks++; if (n_error - e0 !== 1)        begin errors++; $display("FAIL skip_error: got %0d pulses expected 1", n_error - e0); end
    checks++; if (n_valid - v0 !== 0)        begin errors++; $display("FAIL skip_valid: got %0d pulses expected 0", n_valid - v0); end
    checks++; if (frame !== last_frame)      begin errors++; $display("FAIL skip_frame: got %h expected %h", frame, last_frame); end
    checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL skip_count: got %0d expected %0d", frame_count, exp_count); end
    checks++; if (dut.state_q !== HUNT)      begin errors++; $display("FAIL skip_state: got %0d expected HUNT", dut.state_q); end
  endtask

  task automatic test_restart();
    int v0 = n_valid, e0 = n_error;
    logic [34:0] a = rand_pat();
    logic [34:0] b = ~a;
    scan_cols(a, 0, 2, 10, 1'b0);
    expect_frame(b);
    scan_cols(b, 0, 6, 10, 1'b0);
    hold(7'd0, 5'd0, 30);
    checks++; if (n_error - e0 !== 1)  begin errors++; $display("FAIL restart_error: got %0d pulses expected 1", n_error - e0); end
    checks++; if (n_valid - v0 !== 1)  begin errors++; $display("FAIL restart_valid: got %0d pulses expected 1", n_valid - v0); end
    checks++; if (frame !== b)         begin errors++; $display("FAIL restart_frame: got %h expected %h", frame, b); end
    check_drained("restart");
  endtask

  task automatic test_blank_mid();
    int v0 = n_valid, e0 = n_error;
    logic [34:0] a = rand_pat();
    logic [34:0] b = rand_pat();
    scan_cols(a, 0, 2, 10, 1'b0);
    hold(7'd0, 5'd0, 20);
    expect_frame(b);
    scan_cols(b, 0, 6, 10, 1'b0);
    hold(7'd0, 5'd0, 30);
    checks++; if (n_error - e0 !== 0)  begin errors++; $display("FAIL blank_error: got %0d pulses expected 0", n_error - e0); end
    checks++; if (n_valid - v0 !== 1)  begin errors++; $display("FAIL blank_valid: got %0d pulses expected 1", n_valid - v0); end
    checks++; if (frame !== b)         begin errors++; $display("FAIL blank_frame: got %h expected %h", frame, b); end
    check_drained("blank");
  endtask

  task automatic test_reset_mid();
    int v0;
    logic [34:0] p = rand_pat();
    scan_cols(p, 0, 3, 10, 1'b0);
    hold(7'b0010000, p[24:20], 7);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (frame !== 35'd0)      begin errors++; $display("FAIL rstmid_frame: got %h expected 0", frame); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b expected 0", frame_error); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", frame_count); end
    exp_count  = '0;
    last_frame = '0;
    col = '0;
    row = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    hold(7'd0, 5'd0, 10);
    v0 = n_valid;
    p = rand_pat();
    expect_frame(p);
    scan_cols(p, 0, 6, 10, 1'b0);
    hold(7'd0, 5'd0, 30);
    checks++; if (n_valid - v0 !== 1)   begin errors++; $display("FAIL rstmid_valid_after: got %0d pulses expected 1", n_valid - v0); end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL rstmid_count_after: got %0d expected 1", frame_count); end
    checks++; if (frame !== p)          begin errors++; $display("FAIL rstmid_frame_after: got %h expected %h", frame, p); end
    check_drained("rstmid");
  endtask

  task automatic test_wrap();
    int v0 = n_valid, e0 = n_error;
    logic [34:0] p;
    // Count is 1 on entry; 255 more frames bring it round to 0.
    for (int f = 0; f < 255; f++) begin
      p = rand_pat();
      expect_frame(p);
      scan_cols(p, 0, 6, 6, 1'b0);
    end
    hold(7'd0, 5'd0, 30);
    checks++; if (n_valid - v0 !== 255) begin errors++; $display("FAIL wrap_valid: got %0d pulses expected 255", n_valid - v0); end
    checks++; if (n_error - e0 !== 0)   begin errors++; $display("FAIL wrap_error: got %0d pulses expected 0", n_error - e0); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", frame_count); end
    check_drained("wrap");
  endtask

  initial begin
    fork
      mon_scoreboard();
    join_none
    test_reset();
    test_clean();
    test_glitch();
    test_skip();
    test_restart();
    test_blank_mid();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_frame_capture.md
# matrix_frame_capture

Receive-side decoder for the column-multiplexed 5x7 LED panel bus, which carries one-hot column strobes and five row lines. It samples the scanned bus, filters glitches during column transitions, and rebuilds the full 35-pixel frame the panel is showing. It is used as a loop-back monitor on the board and as the bench checker for the panel driver.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a column/row pattern is accepted; legal range ≥1.
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `col`  in  7  column strobes C6..C0, active-high, expected one-hot; asynchronous to `clk`.
- `row`  in  5  row lines L4..L0, active-high pixel data for the strobed column; asynchronous to `clk`.
- `frame`  out  35  last complete frame; bit `c*5+r` is row r of column c.
- `frame_valid`  out  1  one-cycle pulse when `frame` is updated.
- `frame_error`  out  1  one-cycle pulse on a scan-order or one-hot violation.
- `frame_count`  out  8  count of completed frames, wraps 255→0.

## Operation
- Input sync: 2-flop synchronizer on all 12 input bits, giving sample `s = {col,row}`.
- Stability filter:
  - `cnt` clears to 0 whenever `s` differs from the previous `s`.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
  - `accept` is asserted for exactly one cycle, the cycle in which `cnt` steps to `STABLE_CYCLES`.
  - A held pattern is accepted once only.
- Classification of accepted `col`:
  - BLANK: all zero (panel disabled).
  - ONEHOT: index 0..6.
  - MULTI: two or more bits set.
- State machine with states HUNT and COLLECT; register `expect` (3 bits); 35-bit shadow buffer.
- HUNT:
  - ONEHOT index 0: store `row` in shadow column 0, set `expect`=1, go to COLLECT.
  - Any other ONEHOT index, or BLANK: ignored, no error.
  - MULTI: pulse `frame_error`, stay in HUNT.
- COLLECT:
  - ONEHOT index == `expect`: store `row` in that shadow column, increment `expect`.
    - If index was 6: copy shadow plus this column into `frame`, pulse `frame_valid`, increment `frame_count`, go to HUNT.
  - ONEHOT index 0 (early restart): pulse `frame_error`, clear shadow, store column 0, set `expect`=1, stay in COLLECT.
  - ONEHOT any other index ≠ `expect`: pulse `frame_error`, go to HUNT.
  - BLANK: go to HUNT with no error; the partial frame is discarded.
  - MULTI: pulse `frame_error`, go to HUNT.
- Re-accepting the column just stored is impossible, because the filter accepts a held pattern only once. A repeated column only reappears after an intervening different stable pattern. That pattern is necessarily BLANK, MULTI or another index, and is handled by the rules above.
- `frame` is only ever written as a whole; partial frames never reach the output.

## Timing
- Reset values:
  - `frame`=0, `frame_valid`=0, `frame_error`=0, `frame_count`=0.
  - State HUNT, `expect`=0, `cnt`=0.
  - Sync flops and shadow buffer = 0.
- Input change first visible in `s` 2 cycles after the first capturing edge.
- Pattern stable from edge k:
  - `accept` at cycle k+2+`STABLE_CYCLES`.
  - Resulting `frame`, `frame_valid`, `frame_error` and `frame_count` are registered at cycle k+3+`STABLE_CYCLES`.
- Minimum usable column dwell: `STABLE_CYCLES`+1 clocks. Shorter dwells are filtered out, so the column is missed and a scan-order error results on the next accepted column.
- `frame_valid` and `frame_error` are never asserted in the same cycle.
- `rst_n` low mid-frame clears everything immediately, asynchronously. Release is synchronous to `clk` via the design-wide reset synchronizer; the first accepted pattern comes no earlier than `STABLE_CYCLES`+3 cycles after release.

## Structure
- Shared package `panel_pkg`:
  - constants `PANEL_ROWS`=5 and `PANEL_COLS`=7;
  - state enum {HUNT, COLLECT};
  - function `col_index` (one-hot to index) plus a one-hot check, reused by the driver-side bench.
- Sub-module `sample_filter`: synchronizer, stability counter and `accept` strobe, parameterized by width and `STABLE_CYCLES`.
- Top level holds the FSM, shadow buffer and output registers.

## Test plan
- Clean scan, `STABLE_CYCLES`=4, dwell 10 clocks per column, columns 0..6 with rows 5'b10101 / 01110 / 11111 / 00000 / 10001 / 01010 / 00100:
  - exactly one `frame_valid`;
  - `frame` matches the packed pattern;
  - `frame_count`=1;
  - no `frame_error`.
- Glitch between columns: a 2-clock dwell of `col`=7'b0000011 inserted at every transition -> no `accept` for the glitch, no error, frame identical to the clean scan.
- Skipped column (sequence 0,1,2,4) -> `frame_error` on column 4 acceptance, state HUNT, `frame` unchanged, `frame_count` unchanged.
- Early restart (sequence 0,1,2,0,1..6) -> one `frame_error` at the second column 0, then `frame_valid`; `frame` contains only the second scan.
- BLANK mid-frame (0,1,2, then `col`=0 for 20 clocks, then 0..6) -> no error, one `frame_valid` after the full scan.
- `rst_n` pulled low at column 4 of a scan -> all outputs 0 immediately; after release a full scan yields `frame_count`=1.
- 256 clean frames -> `frame_count` wraps to 0.
